// File: rtl/ni_link_arbiter.sv
// ni_link_arbiter: round-robin, packet-locked arbiter sharing one flit link between NI packetizers.
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_flit, i_req_valid   per-requester flit and valid (requester i at bits [i*FLIT_W +: FLIT_W])
//   o_req_ready               per-requester accept (combinational)
//   o_out_flit, o_out_valid   registered output stage toward the router
//   i_out_ready               router accepts the output flit
//   o_grant_id, o_busy        current/last granted requester, high while a packet is locked
//   o_drop_cnt, o_len_err     saturating stray-flit drop count, sticky over-length flag
module ni_link_arbiter #(
    parameter int                NUM_REQ    = 4,
    parameter int                FLIT_W     = 8,
    parameter logic [5:0]        HEADER_TAG = 6'b101111,
    parameter logic [FLIT_W-1:0] TAIL_FLIT  = 8'hFF,
    parameter int                MAX_BODY   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ*FLIT_W-1:0] i_req_flit,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [FLIT_W-1:0]         o_out_flit,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [1:0]                o_grant_id,
    output logic                      o_busy,
    output logic [7:0]                o_drop_cnt,
    output logic                      o_len_err
);
    localparam int BODY_W = $clog2(MAX_BODY + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_ptr, r_grant, w_win, w_ptr_nxt;
    logic [BODY_W-1:0]   r_body;
    logic                r_hdr_seen, r_out_valid, r_len_err;
    logic [FLIT_W-1:0]   r_out_flit, w_gnt_flit;
    logic [7:0]          r_drop_cnt;
    logic [NUM_REQ-1:0]  w_elig, w_stray;
    logic                w_any, w_gnt_valid, w_slot_free, w_accept, w_is_tail, w_end;
    logic [8:0]          w_drop_sum;

    // Header detection: a flit whose top six bits carry the header tag.
    always_comb begin
        w_elig  = '0;
        w_stray = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i]  = i_req_valid[i] && (i_req_flit[i*FLIT_W+FLIT_W-6 +: 6] == HEADER_TAG);
            w_stray[i] = i_req_valid[i] && !w_elig[i];
        end
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        w_win = r_ptr;
        w_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_win = 2'((int'(r_ptr) + k) % NUM_REQ);
                w_any = 1'b1;
            end
        end
    end

    assign w_gnt_flit  = i_req_flit[int'(r_grant)*FLIT_W +: FLIT_W];
    assign w_gnt_valid = i_req_valid[r_grant];
    assign w_slot_free = !r_out_valid || i_out_ready;
    assign w_accept    = i_rst_n && (r_state == ST_LOCKED) && w_gnt_valid && w_slot_free;
    assign w_is_tail   = (w_gnt_flit == TAIL_FLIT);
    // The first accepted flit of a lock is the header; the packet ends on a tail
    // or on the flit after MAX_BODY body flits, whichever comes first.
    assign w_end       = w_accept && r_hdr_seen && (w_is_tail || r_body == BODY_W'(MAX_BODY));
    assign w_ptr_nxt   = (int'(r_grant) == NUM_REQ - 1) ? 2'd0 : r_grant + 2'd1;
    assign w_drop_sum  = {1'b0, r_drop_cnt} + 9'($countones(w_stray));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE)
            w_state_nxt = w_any ? ST_LOCKED : ST_IDLE;
        else
            w_state_nxt = w_end ? ST_IDLE : ST_LOCKED;
    end

    // In IDLE headers wait (not consumed) while stray flits are swallowed.
    always_comb begin
        o_busy      = (r_state == ST_LOCKED);
        o_req_ready = '0;
        if (i_rst_n) begin
            if (r_state == ST_IDLE)
                o_req_ready = w_stray;
            else
                o_req_ready[r_grant] = w_slot_free;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_body     <= '0;
            r_hdr_seen <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_grant    <= w_win;
                r_body     <= '0;
                r_hdr_seen <= 1'b0;
            end
            if (w_accept) begin
                r_hdr_seen <= 1'b1;
                if (r_hdr_seen && !w_end)
                    r_body <= r_body + BODY_W'(1);
            end
            if (w_end) begin
                r_ptr <= w_ptr_nxt;
                if (!w_is_tail)
                    r_len_err <= 1'b1;
            end
        end
    end

    // Single-entry output register: load and drain in one cycle keeps it full.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_flit  <= w_gnt_flit;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_drop_cnt <= '0;
        else if (r_state == ST_IDLE)
            r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end

    assign o_out_flit  = r_out_flit;
    assign o_out_valid = r_out_valid;
    assign o_grant_id  = r_grant;
    assign o_drop_cnt  = r_drop_cnt;
    assign o_len_err   = r_len_err;
endmodule
